// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a contiguous RAM region out over a valid/ready port
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_WIDTH:0]    rem;          // reads still to be issued
    logic                   rd_pend;      // a read was issued last cycle; its data is on ram_data_out now
    logic                   rd_pend_last; // that read was the final one of the transfer
    logic [1:0]             buf_cnt;      // words held: m_data is the head, buf1 the second slot
    logic                   head_last;
    logic [DATA_WIDTH-1:0]  buf1_data;
    logic                   buf1_last;
    logic                   pop;
    logic                   issue;
    logic                   accept;
    logic [2:0]             occupancy;

    assign busy    = (state != IDLE);
    assign m_valid = (buf_cnt != 2'd0);
    assign m_last  = m_valid & head_last;
    assign pop     = m_valid & m_ready;

    // Reads already in flight reserve a buffer slot, so the buffer can never overflow.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};

    // Next-state and read-issue decision
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                issue = (occupancy < 3'd2);
                if (issue && (rem == LEN_ONE)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, address generation, completion pulse and the two-entry output buffer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            done         <= 1'b0;
            ram_addr_r   <= '0;
            rem          <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            buf_cnt      <= 2'd0;
            m_data       <= '0;
            head_last    <= 1'b0;
            buf1_data    <= '0;
            buf1_last    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= ((state == DRAIN) && pop && head_last) ||
                     ((state == IDLE) && start && (length == '0));

            if (accept) begin
                ram_addr_r <= start_addr;
                rem        <= length;
            end else if (issue) begin
                ram_addr_r <= ram_addr_r + ADDR_ONE;
                rem        <= rem - LEN_ONE;
            end

            rd_pend      <= issue;
            rd_pend_last <= issue && (rem == LEN_ONE);

            case ({rd_pend, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        m_data    <= ram_data_out;
                        head_last <= rd_pend_last;
                    end else begin
                        buf1_data <= ram_data_out;
                        buf1_last <= rd_pend_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    m_data    <= buf1_data;
                    head_last <= buf1_last;
                    buf_cnt   <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        m_data    <= ram_data_out;
                        head_last <= rd_pend_last;
                    end else begin
                        m_data    <= buf1_data;
                        head_last <= buf1_last;
                        buf1_data <= ram_data_out;
                        buf1_last <= rd_pend_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - randomized self-checking bench for ram_stream_reader
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          m_ready = 1'b0;
    logic          busy, done, m_valid, m_last;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_data_out, m_data;

    logic [7:0] mem [0:4095];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int expq[$];
    int log_q[$];
    bit chk_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    int first_valid_cyc = -1;
    bit prev_busy = 1'b0;
    bit prev_lasths = 1'b0;

    always #5 clk = ~clk;

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .ram_addr_r(ram_addr_r),
        .ram_data_out(ram_data_out), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always @(posedge clk) ram_data_out <= mem[ram_addr_r];
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        prev_busy   = busy;
        prev_lasths = m_valid && m_ready && m_last;
        if (reset_n && chk_en) begin
            if (prev_stall)
                chk(m_valid && m_data == prev_data && m_last == prev_last, "stall_hold",
                    int'({m_valid, m_last, m_data}), int'({1'b1, prev_last, prev_data}));
            if (m_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (expq.size() == 0) begin
                    chk(1'b0, "spurious_valid", int'(m_data), 0);
                end else begin
                    chk(int'({m_last, m_data}) == expq[0], "word", int'({m_last, m_data}), expq[0]);
                    if (m_ready) begin
                        void'(expq.pop_front());
                        log_q.push_back(int'({m_last, m_data}));
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk_zero(input string name);
        chk({busy, done, m_valid, m_last} == 4'b0, name, int'({busy, done, m_valid, m_last}), 0);
        chk(m_data == '0 && ram_addr_r == '0, name, int'({ram_addr_r, m_data}), 0);
    endtask

    task automatic issue_cmd(input logic [AW-1:0] a, input int len, output int c);
        start = 1'b1;
        start_addr = a;
        length = 13'(len);
        c = cyc;
        for (int k = 0; k < len; k++)
            expq.push_back(((k == len - 1) ? 256 : 0) + int'(mem[12'(int'(a) + k)]));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit noisy, input bit chk_busy,
                             output int dcyc, output bit got);
        got = 1'b0;
        dcyc = -1;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dcyc = cyc;
                chk(!busy, "busy_at_done", int'(busy), 0);
            end else begin
                if (chk_busy) chk(busy, "busy_high", int'(busy), 1);
                @(posedge clk);
                #1;
                if (noisy && prev_busy && !prev_lasths && $urandom_range(0, 2) == 0) begin
                    start = 1'b1;
                    start_addr = 12'($urandom);
                    length = 13'($urandom_range(1, 9));
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk(got, "done_timeout", int'(got), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk(!done, "done_one_cycle", int'(done), 0);
    endtask

    task automatic chk_log(input string name, input int exp_words[$]);
        chk(log_q.size() == exp_words.size(), {name, "_count"}, log_q.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < log_q.size(); i++)
            chk(log_q[i] == exp_words[i], name, log_q[i], exp_words[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, dc, len, nl;
        bit got;
        logic [AW-1:0] a;

        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_outputs");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic transfer
        rdy_mode = 0;
        log_q.delete();
        first_valid_cyc = -1;
        issue_cmd(12'h010, 4, c);
        wait_done(40, 1'b0, 1'b1, dc, got);
        chk(first_valid_cyc == c + 3, "basic_first_valid", first_valid_cyc - c, 3);
        chk(dc == c + 7, "basic_done_cycle", dc - c, 7);
        chk_log("basic_words", '{32'h10, 32'h11, 32'h12, 32'h113});

        // Backpressure with alternating ready
        rdy_mode = 1;
        log_q.delete();
        issue_cmd(12'h010, 4, c);
        wait_done(60, 1'b0, 1'b1, dc, got);
        chk_log("bp_words", '{32'h10, 32'h11, 32'h12, 32'h113});

        // Address wrap
        rdy_mode = 0;
        log_q.delete();
        issue_cmd(12'hFFE, 4, c);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(ram_addr_r == 12'(12'hFFE + k), "wrap_addr", int'(ram_addr_r), int'(12'(12'hFFE + k)));
        end
        wait_done(40, 1'b0, 1'b0, dc, got);
        chk_log("wrap_words", '{32'hFE, 32'hFF, 32'h00, 32'h101});

        // Zero length
        log_q.delete();
        issue_cmd(12'h123, 0, c);
        chk(!busy, "zero_busy", int'(busy), 0);
        wait_done(10, 1'b0, 1'b0, dc, got);
        chk(dc == c + 1, "zero_done_cycle", dc - c, 1);
        chk(log_q.size() == 0, "zero_no_words", log_q.size(), 0);

        // Start accepted in the same cycle as done
        log_q.delete();
        issue_cmd(12'h020, 3, c);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk(done, "b2b_done_first", int'(done), 1);
        issue_cmd(12'h040, 2, c2);
        wait_done(40, 1'b0, 1'b1, dc, got);
        chk(dc == c2 + 5, "b2b_done_second", dc - c2, 5);
        chk_log("b2b_words", '{32'h20, 32'h21, 32'h122, 32'h40, 32'h141});

        // Start while busy is ignored
        rdy_mode = 2;
        log_q.delete();
        issue_cmd(12'h300, 10, c);
        wait_done(200, 1'b1, 1'b1, dc, got);
        chk(log_q.size() == 10, "busy_start_count", log_q.size(), 10);

        // Reset one cycle after the second word
        rdy_mode = 0;
        log_q.delete();
        issue_cmd(12'h010, 8, c);
        for (int k = 0; k < 20 && log_q.size() < 2; k++) @(posedge clk);
        chk(log_q.size() == 2, "rst_two_words", log_q.size(), 2);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midreset_outputs");
        expq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk(!m_valid && !busy, "post_reset_quiet", int'({m_valid, busy}), 0);
        end
        @(posedge clk);
        #1;

        // Full depth
        log_q.delete();
        issue_cmd(12'h800, 4096, c);
        wait_done(4300, 1'b0, 1'b1, dc, got);
        chk(dc == c + 4099, "full_done_cycle", dc - c, 4099);
        chk(log_q.size() == 4096, "full_count", log_q.size(), 4096);
        nl = 0;
        foreach (log_q[i]) if (log_q[i] >= 256) nl++;
        chk(nl == 1, "full_last_count", nl, 1);
        if (log_q.size() == 4096) chk(log_q[4095] == 32'h1FF, "full_last_word", log_q[4095], 32'h1FF);

        // Randomized transfers
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 25; t++) begin
            rdy_mode = $urandom_range(0, 2);
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            a = 12'($urandom);
            issue_cmd(a, len, c);
            wait_done(len * 8 + 30, 1'b1, len != 0, dc, got);
            if (rdy_mode == 0)
                chk(dc == c + ((len == 0) ? 1 : len + 3), "rand_done_cycle", dc - c, (len == 0) ? 1 : len + 3);
            chk(expq.size() == 0, "rand_drained", expq.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
